// File: rtl/bip_fetch_unit.sv
// Instruction fetch/sequencer for the BIP accumulator CPU: owns the PC, reads the synchronous
// program ROM and hands each latched word to the decoder with a one-cycle valid strobe.
module bip_fetch_unit #(
   parameter int unsigned PC_WIDTH  = 11,
   parameter int unsigned OP_WIDTH  = 5,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic                         i_start,
   input  logic                         i_step_mode,
   input  logic                         i_step,
   input  logic                         i_WrPC,
   input  logic [OP_WIDTH+PC_WIDTH-1:0] i_prog_data,
   output logic [PC_WIDTH-1:0]          o_prog_addr,
   output logic [OP_WIDTH-1:0]          o_OPcode,
   output logic [PC_WIDTH-1:0]          o_operand,
   output logic                         o_instr_valid,
   output logic                         o_busy,
   output logic                         o_halted,
   output logic [CNT_WIDTH-1:0]         o_instr_count
);

   localparam int unsigned InstrWidth = OP_WIDTH + PC_WIDTH;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StExec,
      StStepWait,
      StHalted
   } state_e;

   state_e                r_state, w_state_d;
   logic [PC_WIDTH-1:0]   r_pc, w_pc_d;
   logic [InstrWidth-1:0] r_instr, w_instr_d;
   logic [CNT_WIDTH-1:0]  r_count, w_count_d;
   logic                  w_is_halt;

   assign w_is_halt = (r_instr[InstrWidth-1 -: OP_WIDTH] == '0);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_pc    <= '0;
         r_instr <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_d;
         r_pc    <= w_pc_d;
         r_instr <= w_instr_d;
         r_count <= w_count_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      w_instr_d = r_instr;
      w_count_d = r_count;
      unique case (r_state)
         StIdle, StHalted: begin
            // A (re)start clears PC and count on the same edge that enters FETCH.
            if (i_start) begin
               w_pc_d    = '0;
               w_count_d = '0;
               w_state_d = StFetch;
            end
         end
         StFetch: w_state_d = StLatch;
         StLatch: begin
            w_instr_d = i_prog_data;
            w_state_d = StExec;
         end
         StExec: begin
            if (r_count != '1) begin
               w_count_d = r_count + CNT_WIDTH'(1);
            end
            if (w_is_halt) begin
               w_state_d = StHalted;
            end else begin
               if (i_WrPC) begin
                  w_pc_d = r_pc + PC_WIDTH'(1);
               end
               w_state_d = i_step_mode ? StStepWait : StFetch;
            end
         end
         StStepWait: begin
            if (i_step) begin
               w_state_d = StFetch;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign o_prog_addr   = r_pc;
   assign o_OPcode      = r_instr[InstrWidth-1 -: OP_WIDTH];
   assign o_operand     = r_instr[PC_WIDTH-1:0];
   assign o_instr_valid = (r_state == StExec);
   assign o_busy        = (r_state == StFetch) || (r_state == StLatch) ||
                          (r_state == StExec)  || (r_state == StStepWait);
   assign o_halted      = (r_state == StHalted);
   assign o_instr_count = r_count;

endmodule

// File: tb/tb_bip_fetch_unit.sv
// Scoreboard bench for bip_fetch_unit: a program-level model queues the expected strobes and
// per-strobe monitors compare them; a narrow second instance covers PC wrap and count saturation.
module tb_bip_fetch_unit;

   typedef struct {
      int unsigned op;
      int unsigned operand;
      int unsigned pc;
      int unsigned cnt;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, step_mode, step, wrpc;
   logic [15:0] prog_data;
   logic [10:0] addr, operand;
   logic [4:0]  opcode;
   logic        valid, busy, halted;
   logic [15:0] count;

   logic        s_start;
   logic [7:0]  s_prog_data;
   logic [2:0]  s_addr, s_operand;
   logic [4:0]  s_opcode;
   logic        s_valid, s_busy, s_halted;
   logic [1:0]  s_count;

   logic [15:0] rom [2048];
   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   exp_t        q_main[$];
   exp_t        q_small[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROMs: data for an address appears one edge later.
   always @(posedge clk) prog_data <= rom[addr];
   always @(posedge clk) s_prog_data <= {5'b00100, s_addr};

   bip_fetch_unit dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_step_mode(step_mode), .i_step(step),
      .i_WrPC(wrpc), .i_prog_data(prog_data), .o_prog_addr(addr), .o_OPcode(opcode),
      .o_operand(operand), .o_instr_valid(valid), .o_busy(busy), .o_halted(halted),
      .o_instr_count(count)
   );

   bip_fetch_unit #(.PC_WIDTH(3), .OP_WIDTH(5), .CNT_WIDTH(2)) dut_small (
      .i_clock(clk), .i_reset(rst), .i_start(s_start), .i_step_mode(1'b0), .i_step(1'b0),
      .i_WrPC(1'b1), .i_prog_data(s_prog_data), .o_prog_addr(s_addr), .o_OPcode(s_opcode),
      .o_operand(s_operand), .o_instr_valid(s_valid), .o_busy(s_busy), .o_halted(s_halted),
      .o_instr_count(s_count)
   );

   task automatic check(input string name, input longint unsigned act,
                        input longint unsigned exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon_main
      exp_t e;
      if (!rst && valid) begin
         if (q_main.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            e = q_main.pop_front();
            check("opcode", opcode, e.op);
            check("operand", operand, e.operand);
            check("exec_pc", addr, e.pc);
            check("exec_count", count, e.cnt);
            check("strobe_cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_small
      exp_t e;
      if (!rst && s_valid) begin
         if (q_small.size() == 0) begin
            check("small_unexpected_strobe", 1, 0);
         end else begin
            e = q_small.pop_front();
            check("small_opcode", s_opcode, e.op);
            check("small_operand", s_operand, e.operand);
            check("small_pc", s_addr, e.pc);
            check("small_count", s_count, e.cnt);
            check("small_strobe_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic do_reset();
      check("main_queue_drained", q_main.size(), 0);
      check("small_queue_drained", q_small.size(), 0);
      rst = 1'b1; start = 1'b0; step = 1'b0; s_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_prog(input int unsigned len);
      for (int i = 0; i < int'(len); i++) begin
         rom[i] = {5'($urandom_range(31, 1)), 11'($urandom)};
      end
      rom[len-1][15:11] = 5'd0;
   endtask

   // Free-run with WrPC=1 until HALT; optional i_start noise while busy must be ignored.
   task automatic run_free(input bit noise);
      int unsigned m, pc, k, h;
      logic [15:0] w;
      step_mode = 1'b0; wrpc = 1'b1;
      m = cyc; start = 1'b1; pc = 0; k = 0;
      forever begin
         w = rom[pc];
         q_main.push_back('{w[15:11], w[10:0], pc, k, m + 3 + 3 * k});
         if (w[15:11] == 5'd0 || k >= 2047) break;
         pc = (pc + 1) % 2048; k++;
      end
      h = m + 3 + 3 * k;
      @(negedge clk);
      start = 1'b0;
      check("start_pc_cleared", addr, 0);
      check("start_count_cleared", count, 0);
      check("start_busy", busy, 1);
      while (cyc < h + 2) begin
         start = (noise && cyc < h) ? ($urandom_range(3) == 0) : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      check("free_halted", halted, 1);
      check("free_busy", busy, 0);
      check("free_final_pc", addr, pc);
      check("free_final_count", count, k + 1);
   endtask

   task automatic run_step(input int unsigned nsteps, input bit wr);
      int unsigned pc, k, c, last_e, dly;
      logic [15:0] w;
      step_mode = 1'b1; wrpc = wr; pc = 0; k = 0;
      c = cyc; start = 1'b1; w = rom[pc];
      q_main.push_back('{w[15:11], w[10:0], pc, k, c + 3});
      last_e = c + 3;
      @(negedge clk);
      start = 1'b0;
      check("step_start_pc", addr, 0);
      while (k < nsteps && w[15:11] != 5'd0) begin
         dly = $urandom_range(3);
         while (cyc < last_e + 1 + dly) @(negedge clk);
         check("park_busy", busy, 1);
         check("park_no_strobe", valid, 0);
         if (wr) pc = (pc + 1) % 2048;
         k++;
         w = rom[pc];
         c = cyc; step = 1'b1; start = 1'($urandom_range(1));
         q_main.push_back('{w[15:11], w[10:0], pc, k, c + 3});
         last_e = c + 3;
         @(negedge clk);
         step = 1'b1; start = 1'b1;
         @(negedge clk);
         step = 1'b0; start = 1'b0;
      end
      while (cyc < last_e + 2) @(negedge clk);
      check("step_end_halted", halted, (w[15:11] == 5'd0));
      check("step_end_busy", busy, (w[15:11] != 5'd0));
      check("step_end_count", count, k + 1);
      check("step_end_pc", addr, (w[15:11] != 5'd0 && wr) ? (pc + 1) % 2048 : pc);
   endtask

   initial begin
      int unsigned m;
      for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
      rst = 1'b1; start = 1'b0; step = 1'b0; step_mode = 1'b0; wrpc = 1'b0; s_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_addr", addr, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_count", count, 0);
      rst = 1'b0;
      @(negedge clk);

      // LOADI 5, ADDI 3, HALT; abort with reset while in LATCH.
      rom[0] = {5'b00011, 11'd5};
      rom[1] = {5'b00101, 11'd3};
      rom[2] = 16'h0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_addr", addr, 0);
      check("midrst_opcode", opcode, 0);
      check("midrst_operand", operand, 0);
      check("midrst_busy", busy, 0);
      check("midrst_valid", valid, 0);
      check("midrst_count", count, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_rst", busy, 0);

      run_free(1'b0);
      check("halt_opcode", opcode, 0);
      run_free(1'b1);

      for (int r = 0; r < 4; r++) begin
         do_reset();
         load_prog($urandom_range(40, 3));
         run_free(1'b1);
         run_free(1'b1);
      end

      for (int r = 0; r < 5; r++) begin
         do_reset();
         load_prog($urandom_range(12, 3));
         run_step($urandom_range(8, 3), (r == 0) ? 1'b0 : 1'($urandom_range(1)));
      end

      // Narrow instance: PC wraps 7 -> 0, count sticks at 3.
      do_reset();
      m = cyc;
      s_start = 1'b1;
      for (int k = 0; k < 10; k++) begin
         q_small.push_back('{4, k % 8, k % 8, (k < 3) ? k : 3, m + 3 + 3 * k});
      end
      @(negedge clk);
      s_start = 1'b0;
      while (cyc < m + 32) @(negedge clk);
      check("small_count_saturated", s_count, 3);
      check("small_busy", s_busy, 1);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
